// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the instruction-cache sequencer.
package icache_pkg;

    // Geometry shared with the 4-way instruction cache
    localparam int unsigned ICACHE_ADDR_W = 20;
    localparam int unsigned WORD_W        = 32;
    localparam int unsigned LINE_BYTES    = 4;
    localparam int unsigned OFFSET_W      = $clog2(LINE_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_CHECK  = 3'd2,
        ST_MREQ   = 3'd3,
        ST_FILL   = 3'd4
    } state_e;

    // Width of a counter that must be able to reach timeout-1 (at least 1 bit)
    function automatic int unsigned wd_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/icache_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count up on inc, hold at all-ones, clear on request
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/icache_ctrl.sv
// Fetch-side sequencer: cache lookup, miss refill from memory, critical-word
// forward, hit/miss statistics and a memory-response watchdog.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W  = ICACHE_ADDR_W,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              instr_valid,
    output logic [WORD_W-1:0] instr,
    output logic              cache_read_en,
    output logic              cache_fetch,
    output logic [ADDR_W-1:0] cache_read_addr,
    output logic [ADDR_W-1:0] cache_write_addr,
    output logic [WORD_W-1:0] cache_write_data,
    input  logic              cache_miss,
    input  logic [WORD_W-1:0] cache_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              mem_err,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    localparam int unsigned WD_W    = wd_width(TIMEOUT);
    localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    state_e              r_state;
    logic [ADDR_W-1:0]   r_addr_q;
    logic [WORD_W-1:0]   r_data_q;
    logic [WORD_W-1:0]   r_instr;
    logic                r_instr_valid;
    logic                r_req_ready;
    logic                r_read_en;
    logic                r_fetch;
    logic                r_mem_req;
    logic                r_mem_err;

    logic [ADDR_W-1:0]   w_addr_aligned;
    logic                w_hit;
    logic                w_miss;
    logic                w_in_mreq;
    logic                w_wd_inc;
    logic [WD_W-1:0]     w_wd_count;
    logic                w_wd_expired;

    // Word-align the incoming fetch address (byte offset is don't-care)
    assign w_addr_aligned = req_addr & ~ADDR_W'(LINE_BYTES - 1);

    assign w_in_mreq    = (r_state == ST_MREQ);
    assign w_hit        = (r_state == ST_CHECK) && !cache_miss;
    assign w_miss       = (r_state == ST_CHECK) &&  cache_miss;
    assign w_wd_inc     = w_in_mreq && !mem_ack;
    // Last waiting cycle reached with no ack; a zero TIMEOUT never expires
    assign w_wd_expired = (TIMEOUT != 0) && w_in_mreq && !mem_ack
                          && (w_wd_count == WD_W'(TO_LAST));

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_clr   (1'b0),
        .i_inc   (w_hit),
        .o_count (hit_count)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_clr   (1'b0),
        .i_inc   (w_miss),
        .o_count (miss_count)
    );

    // Watchdog counts waiting MREQ cycles; held at zero elsewhere
    sat_counter #(.W(WD_W)) u_wd_cnt (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_clr   (!w_in_mreq),
        .i_inc   (w_wd_inc),
        .o_count (w_wd_count)
    );

    // Sequencer: state and all control outputs registered together
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= ST_IDLE;
            r_addr_q      <= '0;
            r_data_q      <= '0;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_req_ready   <= 1'b1;
            r_read_en     <= 1'b0;
            r_fetch       <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_err     <= 1'b0;
        end else begin
            r_instr_valid <= 1'b0;
            r_read_en     <= 1'b0;
            r_fetch       <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr_q    <= w_addr_aligned;
                        r_read_en   <= 1'b1;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    r_state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (!cache_miss) begin
                        r_instr       <= cache_rdata;
                        r_instr_valid <= 1'b1;
                        r_req_ready   <= 1'b1;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_mem_req <= 1'b1;
                        r_state   <= ST_MREQ;
                    end
                end
                ST_MREQ: begin
                    if (mem_ack) begin
                        r_data_q  <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_fetch   <= 1'b1;
                        r_state   <= ST_FILL;
                    end else if (w_wd_expired) begin
                        r_mem_req     <= 1'b0;
                        r_mem_err     <= 1'b1;
                        r_instr       <= '0;
                        r_instr_valid <= 1'b1;
                        r_req_ready   <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                ST_FILL: begin
                    // Forward the refilled word directly, no second lookup
                    r_instr       <= r_data_q;
                    r_instr_valid <= 1'b1;
                    r_req_ready   <= 1'b1;
                    r_state       <= ST_IDLE;
                end
                default: begin
                    r_mem_req   <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready        = r_req_ready;
    assign instr_valid      = r_instr_valid;
    assign instr            = r_instr;
    assign cache_read_en    = r_read_en;
    assign cache_fetch      = r_fetch;
    assign cache_read_addr  = r_addr_q;
    assign cache_write_addr = r_addr_q;
    assign cache_write_data = r_data_q;
    assign mem_req          = r_mem_req;
    assign mem_addr         = r_addr_q;
    assign mem_err          = r_mem_err;

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a behavioural cache and memory responder.
module tb_icache_ctrl;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic [19:0] req_addr;
    logic        req_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic        cache_read_en;
    logic        cache_fetch;
    logic [19:0] cache_read_addr;
    logic [19:0] cache_write_addr;
    logic [31:0] cache_write_data;
    logic        cache_miss;
    logic [31:0] cache_rdata;
    logic        mem_req;
    logic [19:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_errors = 0;

    // memory responder controls
    int          ack_delay = -1;
    logic [31:0] ack_data  = '0;
    logic        late_ack  = 1'b0;
    int          mreq_cyc  = 0;

    // monitor records
    int          fetch_cnt   = 0;
    int          overlap_cnt = 0;
    int          mreq_total  = 0;
    int          valid_cnt   = 0;
    logic [19:0] last_rd_addr  = '0;
    logic [19:0] last_mem_addr = '0;
    logic [19:0] last_wr_addr  = '0;
    logic [31:0] last_wr_data  = '0;

    logic [31:0] lines [logic [19:0]];

    icache_ctrl #(.ADDR_W(20), .TIMEOUT(4), .CNT_W(32)) dut (
        .CLK              (CLK),
        .RST              (RST),
        .req_valid        (req_valid),
        .req_addr         (req_addr),
        .req_ready        (req_ready),
        .instr_valid      (instr_valid),
        .instr            (instr),
        .cache_read_en    (cache_read_en),
        .cache_fetch      (cache_fetch),
        .cache_read_addr  (cache_read_addr),
        .cache_write_addr (cache_write_addr),
        .cache_write_data (cache_write_data),
        .cache_miss       (cache_miss),
        .cache_rdata      (cache_rdata),
        .mem_req          (mem_req),
        .mem_addr         (mem_addr),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .mem_err          (mem_err),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cache model: answers a read in the following cycle, stores refills
    initial begin
        cache_miss  = 1'b0;
        cache_rdata = '0;
    end
    always @(negedge CLK) begin
        if (cache_fetch) lines[cache_write_addr] = cache_write_data;
        if (cache_read_en) begin
            if (lines.exists(cache_read_addr)) begin
                cache_miss  = 1'b0;
                cache_rdata = lines[cache_read_addr];
            end else begin
                cache_miss  = 1'b1;
                cache_rdata = 32'hCAFE_0000;
            end
        end
    end

    // Memory model: ack after ack_delay waiting cycles; late_ack forces a stray ack
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
    end
    always @(negedge CLK) begin
        mem_ack = 1'b0;
        if (late_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 32'hBAD0_BAD0;
        end else if (mem_req) begin
            if (ack_delay >= 0 && mreq_cyc == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = ack_data;
            end
            mreq_cyc++;
        end else begin
            mreq_cyc = 0;
        end
    end

    // Event recorder for pulses and addresses seen on the interfaces
    always @(negedge CLK) begin
        if (cache_read_en) last_rd_addr = cache_read_addr;
        if (cache_fetch) begin
            fetch_cnt++;
            last_wr_addr = cache_write_addr;
            last_wr_data = cache_write_data;
        end
        if (cache_read_en && cache_fetch) overlap_cnt++;
        if (mem_req) begin
            mreq_total++;
            last_mem_addr = mem_addr;
        end
        if (instr_valid) valid_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next falling edge
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    // Present one request, then count cycles until instr_valid (bounded)
    task automatic issue(input logic [19:0] addr, output int lat);
        req_valid = 1'b1;
        req_addr  = addr;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (!instr_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int          lat;
        int          m0;
        int          f0;
        int          v0;
        int          n;
        logic [19:0] b2b_addr [3];
        logic [31:0] b2b_data [3];

        RST       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        repeat (3) tick();

        check("rst_req_ready",   64'(req_ready),     64'(1));
        check("rst_instr_valid", 64'(instr_valid),   64'(0));
        check("rst_instr",       64'(instr),         64'(0));
        check("rst_mem_req",     64'(mem_req),       64'(0));
        check("rst_read_en",     64'(cache_read_en), 64'(0));
        check("rst_fetch",       64'(cache_fetch),   64'(0));
        check("rst_mem_err",     64'(mem_err),       64'(0));
        check("rst_hit_count",   64'(hit_count),     64'(0));
        check("rst_miss_count",  64'(miss_count),    64'(0));
        RST = 1'b0;
        tick();

        // Cold miss, ack on the fourth MREQ cycle
        ack_delay = 3;
        ack_data  = 32'hDEAD_BEEF;
        issue(20'h00104, lat);
        check("cold_latency",    64'(lat),          64'(8));
        check("cold_instr",      64'(instr),        64'(32'hDEAD_BEEF));
        check("cold_rd_addr",    64'(last_rd_addr), 64'(20'h00104));
        check("cold_mem_addr",   64'(last_mem_addr),64'(20'h00104));
        check("cold_fetch_cnt",  64'(fetch_cnt),    64'(1));
        check("cold_wr_addr",    64'(last_wr_addr), 64'(20'h00104));
        check("cold_wr_data",    64'(last_wr_data), 64'(32'hDEAD_BEEF));
        check("cold_mreq_cyc",   64'(mreq_total),   64'(4));
        check("cold_miss_count", 64'(miss_count),   64'(1));
        check("cold_hit_count",  64'(hit_count),    64'(0));
        tick();
        check("cold_valid_pulse",64'(instr_valid),  64'(0));

        // Hit after fill
        m0 = mreq_total;
        issue(20'h00104, lat);
        check("hit_latency",     64'(lat),               64'(3));
        check("hit_instr",       64'(instr),             64'(32'hDEAD_BEEF));
        check("hit_no_mreq",     64'(mreq_total - m0),   64'(0));
        check("hit_count_1",     64'(hit_count),         64'(1));

        // Unaligned miss, ack in the first MREQ cycle
        ack_delay = 0;
        ack_data  = 32'h1234_5678;
        issue(20'h00307, lat);
        check("unal_miss_latency", 64'(lat),           64'(5));
        check("unal_rd_addr",      64'(last_rd_addr),  64'(20'h00304));
        check("unal_mem_addr",     64'(last_mem_addr), 64'(20'h00304));
        check("unal_wr_addr",      64'(last_wr_addr),  64'(20'h00304));
        check("unal_instr",        64'(instr),         64'(32'h1234_5678));
        check("unal_miss_count",   64'(miss_count),    64'(2));

        // Unaligned hit on the first line
        issue(20'h00107, lat);
        check("unal_hit_latency",  64'(lat),           64'(3));
        check("unal_hit_rd_addr",  64'(last_rd_addr),  64'(20'h00104));
        check("unal_hit_instr",    64'(instr),         64'(32'hDEAD_BEEF));

        // Timeout: memory never answers
        ack_delay = -1;
        m0 = mreq_total;
        f0 = fetch_cnt;
        issue(20'h00400, lat);
        check("to_latency",    64'(lat),             64'(7));
        check("to_instr",      64'(instr),           64'(0));
        check("to_mreq_cyc",   64'(mreq_total - m0), 64'(4));
        check("to_mem_req",    64'(mem_req),         64'(0));
        check("to_mem_err",    64'(mem_err),         64'(1));
        check("to_no_fetch",   64'(fetch_cnt - f0),  64'(0));
        check("to_miss_count", 64'(miss_count),      64'(3));
        repeat (2) tick();
        check("to_err_sticky", 64'(mem_err),         64'(1));

        // Reset while waiting for memory, then a stray ack
        req_valid = 1'b1;
        req_addr  = 20'h00500;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!mem_req && n < 10) begin
            tick();
            n++;
        end
        check("mr_reached_mreq", 64'(mem_req), 64'(1));
        tick();
        RST = 1'b1;
        #1;
        check("mr_mem_req",    64'(mem_req),       64'(0));
        check("mr_req_ready",  64'(req_ready),     64'(1));
        check("mr_read_en",    64'(cache_read_en), 64'(0));
        check("mr_fetch",      64'(cache_fetch),   64'(0));
        check("mr_mem_err",    64'(mem_err),       64'(0));
        check("mr_miss_count", 64'(miss_count),    64'(0));
        tick();
        RST = 1'b0;
        f0 = fetch_cnt;
        v0 = valid_cnt;
        late_ack = 1'b1;
        repeat (2) tick();
        late_ack = 1'b0;
        tick();
        check("mr_late_no_fetch", 64'(fetch_cnt - f0), 64'(0));
        check("mr_late_no_valid", 64'(valid_cnt - v0), 64'(0));
        check("mr_idle_ready",    64'(req_ready),      64'(1));

        // Back-to-back hits with req_valid held high
        b2b_addr[0] = 20'h00104; b2b_data[0] = 32'hDEAD_BEEF;
        b2b_addr[1] = 20'h00304; b2b_data[1] = 32'h1234_5678;
        b2b_addr[2] = 20'h00106; b2b_data[2] = 32'hDEAD_BEEF;
        f0 = fetch_cnt;
        m0 = mreq_total;
        req_valid = 1'b1;
        req_addr  = b2b_addr[0];
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i < 2) req_addr = b2b_addr[i+1];
            lat = 1;
            while (!instr_valid && lat < 20) begin
                tick();
                lat++;
            end
            check($sformatf("b2b_latency_%0d", i), 64'(lat),   64'(3));
            check($sformatf("b2b_instr_%0d", i),   64'(instr), 64'(b2b_data[i]));
            if (i == 2) req_valid = 1'b0;
        end
        tick();
        check("b2b_hit_count",  64'(hit_count),         64'(3));
        check("b2b_miss_count", 64'(miss_count),        64'(0));
        check("b2b_no_fetch",   64'(fetch_cnt - f0),    64'(0));
        check("b2b_no_mreq",    64'(mreq_total - m0),   64'(0));
        check("no_overlap",     64'(overlap_cnt),       64'(0));
        check("b2b_idle_ready", 64'(req_ready),         64'(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got stuck expected finish");
        $fatal(1);
    end

endmodule
